universal_shift_register: RTL and testbench

- Parametrised successor to the single-bit serial shift register.
- Width is parameterised, and the shift step is LANE bits.
- Supports logical, rotate and arithmetic modes, synchronous parallel load, and serial-out.
- Adds a counted burst engine (start/busy/done) so a controller can request N shift steps and wait for completion. Used for serializers, barrel-free multi-step shifts and CRC/LFSR front-ends.

---
 rtl/universal_shift_register.sv | 153 +++++++++++++++
 tb/tb_universal_shift_register.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// Parameterised LANE-wide shift register with logical/rotate/arithmetic modes,
// parallel load, serial out and a counted burst engine (start/busy/done).
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int LANE  = 1,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             start_i,
  input  logic [CW-1:0]    count_i,
  input  logic [LANE-1:0]  ser_i,
  output logic [LANE-1:0]  ser_o,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [2:0]    MODE_LSL  = 3'b000;
  localparam logic [2:0]    MODE_LSR  = 3'b001;
  localparam logic [2:0]    MODE_ROL  = 3'b010;
  localparam logic [2:0]    MODE_ROR  = 3'b011;
  localparam logic [2:0]    MODE_ASR  = 3'b100;
  localparam logic [2:0]    MODE_HOLD = 3'b101;
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  state_t           state_r, state_n;
  logic [WIDTH-1:0] data_r, data_n;
  logic [CW-1:0]    cnt_r, cnt_n;
  logic [2:0]       mode_r, mode_n;
  logic             busy_r, done_r;
  logic [2:0]       eff_mode_s;
  logic [LANE-1:0]  ser_s;

  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] r,
    input logic [2:0]       m,
    input logic [LANE-1:0]  s
  );
    case (m)
      MODE_LSL: return {r[WIDTH-LANE-1:0], s};
      MODE_LSR: return {s, r[WIDTH-1:LANE]};
      MODE_ROL: return {r[WIDTH-LANE-1:0], r[WIDTH-1:WIDTH-LANE]};
      MODE_ROR: return {r[LANE-1:0], r[WIDTH-1:LANE]};
      MODE_ASR: return {{LANE{r[WIDTH-1]}}, r[WIDTH-1:LANE]};
      default:  return r;
    endcase
  endfunction

  // A running burst uses the mode captured at start; otherwise mode_i drives.
  assign eff_mode_s = (state_r == ST_BUSY) ? mode_r : mode_i;

  // Lane that would leave the register on a step in the effective mode.
  always_comb begin
    ser_s = {LANE{1'b0}};
    case (eff_mode_s)
      MODE_LSL, MODE_ROL:           ser_s = data_r[WIDTH-1:WIDTH-LANE];
      MODE_LSR, MODE_ROR, MODE_ASR: ser_s = data_r[LANE-1:0];
      default:                      ser_s = {LANE{1'b0}};
    endcase
  end

  // Next-state logic: load always wins, then start (IDLE only), then stepping.
  always_comb begin
    state_n = state_r;
    data_n  = data_r;
    cnt_n   = cnt_r;
    mode_n  = mode_r;
    case (state_r)
      ST_IDLE: begin
        if (load_i) begin
          data_n = load_data_i;
        end else if (start_i) begin
          if (count_i != CNT_ZERO) begin
            mode_n  = mode_i;
            cnt_n   = count_i;
            state_n = ST_BUSY;
          end else begin
            state_n = ST_DONE;
          end
        end else if (en_i) begin
          data_n = shift_step(data_r, mode_i, ser_i);
        end else begin
          data_n = data_r;
        end
      end
      ST_BUSY: begin
        if (load_i) begin
          data_n  = load_data_i;
          cnt_n   = CNT_ZERO;
          state_n = ST_IDLE;
        end else if (en_i) begin
          data_n = shift_step(data_r, mode_r, ser_i);
          cnt_n  = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_BUSY;
          end
        end else begin
          state_n = ST_BUSY;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        if (load_i) begin
          data_n = load_data_i;
        end else begin
          data_n = data_r;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, data and the busy/done decodes, all registered together.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= ST_IDLE;
      data_r  <= {WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
      mode_r  <= MODE_HOLD;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      data_r  <= data_n;
      cnt_r   <= cnt_n;
      mode_r  <= mode_n;
      busy_r  <= (state_n == ST_BUSY);
      done_r  <= (state_n == ST_DONE);
    end
  end

  assign ser_o  = ser_s;
  assign data_o = data_r;
  assign busy_o = busy_r;
  assign done_o = done_r;

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: LANE=1 and LANE=2 instances share control
// inputs and are compared every cycle against an arithmetic reference model.
module tb_universal_shift_register;

  logic       clk = 1'b0, rstn = 1'b1, en = 1'b0, load = 1'b0, start = 1'b0;
  logic [2:0] mode = 3'b101;
  logic [7:0] ld = 8'h00;
  logic [3:0] count = 4'h0;
  logic       ser1 = 1'b0;
  logic [1:0] ser2 = 2'b00;

  logic       so1, b1, b2, dn1, dn2;
  logic [1:0] so2;
  logic [7:0] d1, d2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(8), .LANE(1)) dut1 (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .mode_i(mode), .load_i(load),
    .load_data_i(ld), .start_i(start), .count_i(count), .ser_i(ser1),
    .ser_o(so1), .data_o(d1), .busy_o(b1), .done_o(dn1));

  universal_shift_register #(.WIDTH(8), .LANE(2)) dut2 (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .mode_i(mode), .load_i(load),
    .load_data_i(ld), .start_i(start), .count_i(count), .ser_i(ser2),
    .ser_o(so2), .data_o(d2), .busy_o(b2), .done_o(dn2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: one shift step on a w-bit value, done with plain arithmetic.
  function automatic logic [31:0] mstep(input logic [31:0] r, input logic [2:0] m,
                                        input logic [31:0] s, input int w, input int l);
    logic [31:0] mask, lm;
    mask = (32'h1 << w) - 32'h1;
    lm   = (32'h1 << l) - 32'h1;
    case (m)
      3'd0: return ((r << l) | (s & lm)) & mask;
      3'd1: return (r >> l) | ((s & lm) << (w - l));
      3'd2: return ((r << l) | (r >> (w - l))) & mask;
      3'd3: return ((r >> l) | (r << (w - l))) & mask;
      3'd4: return r[w-1] ? ((r >> l) | (mask & ~(mask >> l))) : (r >> l);
      default: return r;
    endcase
  endfunction

  function automatic logic [31:0] mser(input logic [31:0] r, input logic [2:0] m,
                                       input int w, input int l);
    logic [31:0] lm;
    lm = (32'h1 << l) - 32'h1;
    case (m)
      3'd0, 3'd2:       return (r >> (w - l)) & lm;
      3'd1, 3'd3, 3'd4: return r & lm;
      default:          return 32'h0;
    endcase
  endfunction

  logic [31:0] m_data [2] = '{32'h0, 32'h0};
  logic        m_busy = 1'b0, m_done = 1'b0;
  int          m_left = 0;
  logic [2:0]  m_mode = 3'b101;

  task automatic m_shift(input logic [2:0] md);
    for (int i = 0; i < 2; i++)
      m_data[i] = mstep(m_data[i], md, (i == 0) ? 32'(ser1) : 32'(ser2), 8, i + 1);
  endtask

  // Reference behaviour: burst bookkeeping as a flag pair plus steps remaining.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_data = '{32'h0, 32'h0};
      m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_mode = 3'b101;
    end else if (m_done) begin
      m_done = 1'b0;
      if (load) m_data = '{32'(ld), 32'(ld)};
    end else if (m_busy) begin
      if (load) begin
        m_data = '{32'(ld), 32'(ld)};
        m_busy = 1'b0;
      end else if (en) begin
        m_shift(m_mode);
        m_left--;
        if (m_left == 0) begin m_busy = 1'b0; m_done = 1'b1; end
      end
    end else begin
      if (load) m_data = '{32'(ld), 32'(ld)};
      else if (start) begin
        if (count != 4'h0) begin m_busy = 1'b1; m_left = int'(count); m_mode = mode; end
        else m_done = 1'b1;
      end else if (en) m_shift(mode);
    end
  end

  // Every falling edge: both instances against the reference.
  always @(negedge clk) begin
    logic [2:0] em;
    em = m_busy ? m_mode : mode;
    chk("data_l1", 32'(d1), m_data[0]);
    chk("data_l2", 32'(d2), m_data[1]);
    chk("busy_l1", 32'(b1), 32'(m_busy));
    chk("busy_l2", 32'(b2), 32'(m_busy));
    chk("done_l1", 32'(dn1), 32'(m_done));
    chk("done_l2", 32'(dn2), 32'(m_done));
    chk("ser_l1", 32'(so1), mser(m_data[0], em, 8, 1));
    chk("ser_l2", 32'(so2), mser(m_data[1], em, 8, 2));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [7:0] v);
    load = 1'b1; ld = v;
    cyc();
    load = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (dn1 !== 1'b1 && k < n) begin
      cyc();
      k++;
    end
    chk("burst_done", 32'(dn1), 32'h1);
  endtask

  initial begin
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    #1 rstn = 1'b0;
    #11 rstn = 1'b1;
    cyc();

    // Asynchronous reset in mid-cycle
    load_val(8'hA5);
    chk("load_a5", 32'(d1), 32'hA5);
    #2 rstn = 1'b0;
    #1;
    chk("rst_data", 32'(d1), 32'h0);
    chk("rst_busy", 32'(b1), 32'h0);
    chk("rst_done", 32'(dn1), 32'h0);
    chk("rst_ser", 32'(so1), 32'h0);
    cyc();
    rstn = 1'b1;

    // Continuous LSL
    load_val(8'h81);
    mode = 3'b000; en = 1'b1; ser1 = 1'b0; ser2 = 2'b00;
    #1 chk("lsl_ser_pre", 32'(so1), 32'h1);
    cyc();
    en = 1'b0;
    chk("lsl_l1", 32'(d1), 32'h02);
    chk("lsl_l2", 32'(d2), 32'h04);

    // Burst ROR x3 (mode_i changed mid-burst must not matter)
    load_val(8'h01);
    mode = 3'b011; start = 1'b1; count = 4'd3;
    cyc();
    start = 1'b0; mode = 3'b000; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("ror_busy", 32'(b1), 32'h1);
      cyc();
    end
    en = 1'b0;
    chk("ror_done", 32'(dn1), 32'h1);
    chk("ror_l1", 32'(d1), 32'h20);
    chk("ror_l2", 32'(d2), 32'h04);
    cyc();
    chk("ror_done_end", 32'(dn1), 32'h0);

    // Burst ASR x2 with a two-cycle stall
    load_val(8'h80);
    mode = 3'b100; start = 1'b1; count = 4'd2;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("asr_busy", 32'(b1), 32'h1);
      chk("asr_nodone", 32'(dn1), 32'h0);
      en = pat[i];
      cyc();
    end
    en = 1'b0;
    chk("asr_done", 32'(dn1), 32'h1);
    chk("asr_l1", 32'(d1), 32'hE0);
    chk("asr_l2", 32'(d2), 32'hF8);
    cyc();
    chk("asr_single_pulse", 32'(dn1), 32'h0);

    // Abort with load, then zero-count start
    mode = 3'b001; start = 1'b1; count = 4'd5;
    cyc();
    start = 1'b0; en = 1'b1;
    cyc();
    load = 1'b1; ld = 8'h5A;
    cyc();
    load = 1'b0; en = 1'b0;
    chk("abort_data", 32'(d1), 32'h5A);
    chk("abort_busy", 32'(b1), 32'h0);
    chk("abort_nodone", 32'(dn1), 32'h0);
    cyc();
    chk("abort_nodone2", 32'(dn1), 32'h0);
    start = 1'b1; count = 4'd0;
    cyc();
    start = 1'b0;
    chk("zero_done", 32'(dn1), 32'h1);
    chk("zero_data", 32'(d1), 32'h5A);
    cyc();

    // LANE=2 LSR single step
    load_val(8'hC3);
    mode = 3'b001; ser2 = 2'b10; en = 1'b1;
    #1 chk("lsr2_ser_pre", 32'(so2), 32'h3);
    cyc();
    en = 1'b0;
    chk("lsr2_data", 32'(d2), 32'hB0);

    // Counts beyond WIDTH/LANE: rotates wrap, logical shifts saturate
    load_val(8'h96);
    mode = 3'b010; start = 1'b1; count = 4'd9;
    cyc();
    start = 1'b0; en = 1'b1;
    wait_done(20);
    en = 1'b0;
    chk("rol9_l1", 32'(d1), 32'h2D);
    chk("rol9_l2", 32'(d2), 32'h5A);
    cyc();
    mode = 3'b000; ser1 = 1'b1; ser2 = 2'b11; start = 1'b1; count = 4'd12;
    cyc();
    start = 1'b0; en = 1'b1;
    wait_done(20);
    en = 1'b0;
    chk("lsl12_l1", 32'(d1), 32'hFF);
    chk("lsl12_l2", 32'(d2), 32'hFF);
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
